// File: rtl/cache_mem_beat_pkg.sv
// Shared types and helpers for the cache line to memory beat adapter.
// Default geometry, FSM state encoding and the next-beat search.
package cache_mem_beat_pkg;

  localparam int LINE_SIZE_DEF = 64;
  localparam int BEAT_SIZE_DEF = 16;
  localparam int BEATS         = LINE_SIZE_DEF / BEAT_SIZE_DEF;
  localparam int BEAT_IDX_W    = $clog2(BEATS);

  // Upper bound on beats per line the search helper handles.
  localparam int MAX_BEATS     = 32;
  localparam int MAX_IDX_W     = $clog2(MAX_BEATS);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } req_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } beat_sel_t;

  // Lowest beat index >= from whose byte-enable slice is nonzero.
  // nz holds one OR-reduced bit per byte-enable slice.
  function automatic beat_sel_t next_beat(
    input logic [MAX_BEATS-1:0] nz,
    input int                   from
  );
    beat_sel_t s;
    s = '0;
    for (int i = MAX_BEATS - 1; i >= 0; i--) begin
      if (nz[i] && (i >= from)) begin
        s.found = 1'b1;
        s.idx   = i[MAX_IDX_W-1:0];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/cache_mem_rsp_assembler.sv
// Collects BEATS in-order memory beats into one cache line response.
// Ports: dram_rsp_* beat input, mem_rsp_* line output, clk/reset.
module cache_mem_rsp_assembler
  import cache_mem_beat_pkg::*;
#(
  parameter int BEAT_SIZE = BEAT_SIZE_DEF,
  parameter int NBEATS    = BEATS,
  parameter int TAG_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dram_rsp_valid,
  output logic                          dram_rsp_ready,
  input  logic [BEAT_SIZE*8-1:0]        dram_rsp_data,
  input  logic [TAG_WIDTH-1:0]          dram_rsp_tag,
  output logic                          mem_rsp_valid,
  input  logic                          mem_rsp_ready,
  output logic [NBEATS*BEAT_SIZE*8-1:0] mem_rsp_data,
  output logic [TAG_WIDTH-1:0]          mem_rsp_tag
);

  localparam int IW = $clog2(NBEATS);
  localparam int BW = BEAT_SIZE * 8;

  logic [NBEATS-1:0][BW-1:0] line_q;
  logic [IW-1:0]             cnt_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic                      valid_q;
  logic                      beat_fire;
  logic                      last_beat;

  assign dram_rsp_ready = !valid_q;
  assign beat_fire      = dram_rsp_valid && !valid_q;
  assign last_beat      = (cnt_q == IW'(NBEATS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_q  <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && mem_rsp_ready) begin
        valid_q <= 1'b0;
      end
      if (beat_fire) begin
        line_q[cnt_q] <= dram_rsp_data;
        if (cnt_q == '0) begin
          tag_q <= dram_rsp_tag;
        end
        if (last_beat) begin
          cnt_q   <= '0;
          valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign mem_rsp_valid = valid_q;
  assign mem_rsp_data  = line_q;
  assign mem_rsp_tag   = tag_q;

  // Beats after the first must carry the tag latched from beat 0.
  a_tag_stable: assert property (
    @(posedge clk) disable iff (!reset)
    (beat_fire && cnt_q != '0) |-> (dram_rsp_tag == tag_q)
  );

endmodule

// File: rtl/cache_mem_beat_adapter.sv
// Splits full-line cache memory requests into memory-bus beats and
// reassembles read beats into line responses. Ports: mem_* cache side,
// dram_* beat bus side, clk and active-low async reset.
module cache_mem_beat_adapter
  import cache_mem_beat_pkg::*;
#(
  parameter int LINE_SIZE  = LINE_SIZE_DEF,
  parameter int BEAT_SIZE  = BEAT_SIZE_DEF,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8,
  localparam int NB        = LINE_SIZE / BEAT_SIZE,
  localparam int IW        = $clog2(NB)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_req_valid,
  output logic                       mem_req_ready,
  input  logic                       mem_req_rw,
  input  logic [LINE_SIZE-1:0]       mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]      mem_req_addr,
  input  logic [LINE_SIZE*8-1:0]     mem_req_data,
  input  logic [TAG_WIDTH-1:0]       mem_req_tag,
  output logic                       mem_rsp_valid,
  input  logic                       mem_rsp_ready,
  output logic [LINE_SIZE*8-1:0]     mem_rsp_data,
  output logic [TAG_WIDTH-1:0]       mem_rsp_tag,
  output logic                       dram_req_valid,
  input  logic                       dram_req_ready,
  output logic                       dram_req_rw,
  output logic [BEAT_SIZE-1:0]       dram_req_byteen,
  output logic [ADDR_WIDTH+IW-1:0]   dram_req_addr,
  output logic [BEAT_SIZE*8-1:0]     dram_req_data,
  output logic [TAG_WIDTH-1:0]       dram_req_tag,
  input  logic                       dram_rsp_valid,
  output logic                       dram_rsp_ready,
  input  logic [BEAT_SIZE*8-1:0]     dram_rsp_data,
  input  logic [TAG_WIDTH-1:0]       dram_rsp_tag
);

  localparam int BW = BEAT_SIZE * 8;

  typedef logic [NB-1:0][BW-1:0]        line_t;
  typedef logic [NB-1:0][BEAT_SIZE-1:0] be_t;

  req_state_e            state_q, state_d;
  logic [IW-1:0]         beat_q, beat_d;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  be_t                   be_q;
  line_t                 data_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  load;
  logic                  send;

  be_t                   req_be;
  logic [MAX_BEATS-1:0]  req_nz;
  logic [MAX_BEATS-1:0]  cur_nz;
  beat_sel_t             first_sel;
  beat_sel_t             next_sel;

  assign req_be = mem_req_byteen;

  always_comb begin
    req_nz = '0;
    cur_nz = '0;
    for (int i = 0; i < NB; i++) begin
      req_nz[i] = |req_be[i];
      cur_nz[i] = |be_q[i];
    end
  end

  // Widened index so the search past the last beat finds nothing.
  assign first_sel = next_beat(req_nz, 0);
  assign next_sel  = next_beat(cur_nz, int'(beat_q) + 1);

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    load           = 1'b0;
    mem_req_ready  = 1'b0;
    dram_req_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        mem_req_ready = 1'b1;
        if (mem_req_valid) begin
          load = 1'b1;
          if (!mem_req_rw) begin
            state_d = S_SEND;
            beat_d  = '0;
          end else if (first_sel.found) begin
            state_d = S_SEND;
            beat_d  = IW'(first_sel.idx);
          end
        end
      end
      S_SEND: begin
        dram_req_valid = 1'b1;
        if (dram_req_ready) begin
          if (rw_q && next_sel.found) begin
            beat_d = IW'(next_sel.idx);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (load) begin
        rw_q   <= mem_req_rw;
        addr_q <= mem_req_addr;
        be_q   <= mem_req_byteen;
        data_q <= mem_req_data;
        tag_q  <= mem_req_tag;
      end
    end
  end

  assign send = (state_q == S_SEND);

  assign dram_req_rw   = send && rw_q;
  assign dram_req_addr = {addr_q, beat_q};
  assign dram_req_tag  = tag_q;

  always_comb begin
    dram_req_byteen = '0;
    dram_req_data   = '0;
    if (send) begin
      if (rw_q) begin
        dram_req_byteen = be_q[beat_q];
        dram_req_data   = data_q[beat_q];
      end else begin
        dram_req_byteen = '1;
      end
    end
  end

  cache_mem_rsp_assembler #(
    .BEAT_SIZE (BEAT_SIZE),
    .NBEATS    (NB),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_rsp_asm (
    .clk            (clk),
    .reset          (reset),
    .dram_rsp_valid (dram_rsp_valid),
    .dram_rsp_ready (dram_rsp_ready),
    .dram_rsp_data  (dram_rsp_data),
    .dram_rsp_tag   (dram_rsp_tag),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_ready  (mem_rsp_ready),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag)
  );

endmodule

// File: tb/tb_cache_mem_beat_adapter.sv
// Directed bench for cache_mem_beat_adapter.
// Hand-computed expectations, immediate assertions per check.
module tb_cache_mem_beat_adapter;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_rw;
  logic [63:0]  mem_req_byteen;
  logic [25:0]  mem_req_addr;
  logic [511:0] mem_req_data;
  logic [7:0]   mem_req_tag;
  logic         mem_rsp_valid;
  logic         mem_rsp_ready;
  logic [511:0] mem_rsp_data;
  logic [7:0]   mem_rsp_tag;
  logic         dram_req_valid;
  logic         dram_req_ready;
  logic         dram_req_rw;
  logic [15:0]  dram_req_byteen;
  logic [27:0]  dram_req_addr;
  logic [127:0] dram_req_data;
  logic [7:0]   dram_req_tag;
  logic         dram_rsp_valid;
  logic         dram_rsp_ready;
  logic [127:0] dram_rsp_data;
  logic [7:0]   dram_rsp_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_mem_beat_adapter dut (
    .clk             (clk),
    .reset           (reset),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_rw      (mem_req_rw),
    .mem_req_byteen  (mem_req_byteen),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_req_tag     (mem_req_tag),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_ready   (mem_rsp_ready),
    .mem_rsp_data    (mem_rsp_data),
    .mem_rsp_tag     (mem_rsp_tag),
    .dram_req_valid  (dram_req_valid),
    .dram_req_ready  (dram_req_ready),
    .dram_req_rw     (dram_req_rw),
    .dram_req_byteen (dram_req_byteen),
    .dram_req_addr   (dram_req_addr),
    .dram_req_data   (dram_req_data),
    .dram_req_tag    (dram_req_tag),
    .dram_rsp_valid  (dram_rsp_valid),
    .dram_rsp_ready  (dram_rsp_ready),
    .dram_rsp_data   (dram_rsp_data),
    .dram_rsp_tag    (dram_rsp_tag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rep4(input logic [31:0] w);
    return {4{w}};
  endfunction

  logic [3:0][127:0] wl;
  logic [3:0][127:0] pl;
  logic [3:0][127:0] ql;
  logic [7:0]        pat;
  int                k;

  initial begin
    reset          = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_byteen = '0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b1;
    dram_req_ready = 1'b1;
    dram_rsp_valid = 1'b0;
    dram_rsp_data  = '0;
    dram_rsp_tag   = '0;

    // Reset values
    tick();
    chk("rst_mem_req_ready", mem_req_ready, 1);
    chk("rst_mem_rsp_valid", mem_rsp_valid, 0);
    chk("rst_dram_req_valid", dram_req_valid, 0);
    chk("rst_dram_rsp_ready", dram_rsp_ready, 1);
    chk("rst_dram_req_addr", dram_req_addr, 0);
    chk("rst_dram_req_data", dram_req_data, 0);
    chk("rst_mem_rsp_data", mem_rsp_data, 0);
    chk("rst_mem_rsp_tag", mem_rsp_tag, 0);
    reset = 1'b1;
    tick();

    // Read line 0x1234, tag 0x5A
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = 26'h1234;
    mem_req_tag   = 8'h5A;
    chk("rd_req_ready", mem_req_ready, 1);
    chk("rd_no_comb_valid", dram_req_valid, 0);
    tick();
    mem_req_valid = 1'b0;
    chk("rd_dram_valid", dram_req_valid, 1);
    chk("rd_dram_addr", dram_req_addr, 28'h48D0);
    chk("rd_dram_rw", dram_req_rw, 0);
    chk("rd_dram_byteen", dram_req_byteen, 16'hFFFF);
    chk("rd_dram_data", dram_req_data, 0);
    chk("rd_dram_tag", dram_req_tag, 8'h5A);
    chk("rd_busy", mem_req_ready, 0);
    tick();
    chk("rd_done_valid", dram_req_valid, 0);
    chk("rd_done_ready", mem_req_ready, 1);
    dram_rsp_valid = 1'b1;
    dram_rsp_tag   = 8'h5A;
    dram_rsp_data  = {32{4'hA}};
    tick();
    dram_rsp_data  = {32{4'hB}};
    tick();
    dram_rsp_data  = {32{4'hC}};
    tick();
    dram_rsp_data  = {32{4'hD}};
    chk("rd_b3_ready", dram_rsp_ready, 1);
    chk("rd_b3_no_rsp", mem_rsp_valid, 0);
    tick();
    dram_rsp_valid = 1'b0;
    chk("rd_rsp_valid", mem_rsp_valid, 1);
    chk("rd_rsp_data", mem_rsp_data,
        {{32{4'hD}}, {32{4'hC}}, {32{4'hB}}, {32{4'hA}}});
    chk("rd_rsp_tag", mem_rsp_tag, 8'h5A);
    chk("rd_rsp_stall", dram_rsp_ready, 0);
    tick();
    chk("rd_rsp_taken", mem_rsp_valid, 0);
    chk("rd_rsp_ready_back", dram_rsp_ready, 1);

    // Sparse write: beats 0 and 3 only
    wl[0] = rep4(32'h1111_1111);
    wl[1] = rep4(32'h2222_2222);
    wl[2] = rep4(32'h3333_3333);
    wl[3] = rep4(32'h4444_4444);
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b1;
    mem_req_addr   = 26'h10;
    mem_req_tag    = 8'h07;
    mem_req_byteen = 64'hFFFF_0000_0000_FFFF;
    mem_req_data   = wl;
    tick();
    mem_req_valid = 1'b0;
    chk("wr_b0_valid", dram_req_valid, 1);
    chk("wr_b0_addr", dram_req_addr, 28'h40);
    chk("wr_b0_rw", dram_req_rw, 1);
    chk("wr_b0_byteen", dram_req_byteen, 16'hFFFF);
    chk("wr_b0_data", dram_req_data, wl[0]);
    chk("wr_b0_busy", mem_req_ready, 0);
    tick();
    chk("wr_b3_valid", dram_req_valid, 1);
    chk("wr_b3_addr", dram_req_addr, 28'h43);
    chk("wr_b3_byteen", dram_req_byteen, 16'hFFFF);
    chk("wr_b3_data", dram_req_data, wl[3]);
    chk("wr_b3_busy", mem_req_ready, 0);
    tick();
    chk("wr_end_valid", dram_req_valid, 0);
    chk("wr_end_ready", mem_req_ready, 1);
    chk("wr_no_rsp", mem_rsp_valid, 0);

    // Write with every byte enable clear
    mem_req_valid  = 1'b1;
    mem_req_byteen = '0;
    mem_req_addr   = 26'h99;
    chk("wz_ready", mem_req_ready, 1);
    tick();
    mem_req_valid = 1'b0;
    chk("wz_no_req", dram_req_valid, 0);
    chk("wz_ready_after", mem_req_ready, 1);
    tick();
    chk("wz_no_req2", dram_req_valid, 0);
    chk("wz_no_rsp", mem_rsp_valid, 0);

    // Full write with downstream stalls, read waiting behind it
    for (int i = 0; i < 4; i++) begin
      wl[i] = rep4(32'hC0DE_0000 + 32'(i));
    end
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b1;
    mem_req_addr   = 26'h2A5;
    mem_req_tag    = 8'h0F;
    mem_req_byteen = '1;
    mem_req_data   = wl;
    tick();
    mem_req_rw     = 1'b0;
    mem_req_addr   = 26'h55;
    mem_req_tag    = 8'h01;
    mem_req_byteen = '0;
    mem_req_data   = '0;
    pat = 8'b1011_0010;
    k   = 0;
    for (int c = 0; c < 8; c++) begin
      dram_req_ready = pat[c];
      chk("st_valid", dram_req_valid, 1);
      chk("st_addr", dram_req_addr, 28'hA94 + 28'(k));
      chk("st_data", dram_req_data, wl[k]);
      chk("st_byteen", dram_req_byteen, 16'hFFFF);
      chk("st_busy", mem_req_ready, 0);
      tick();
      if (pat[c]) k++;
    end
    dram_req_ready = 1'b1;
    chk("st_beats", k, 4);
    chk("st_end_valid", dram_req_valid, 0);
    chk("st_next_ready", mem_req_ready, 1);
    tick();
    mem_req_addr = 26'h56;
    mem_req_tag  = 8'h02;
    chk("r1_addr", dram_req_addr, 28'h154);
    chk("r1_tag", dram_req_tag, 8'h01);
    chk("r1_busy", mem_req_ready, 0);
    tick();
    chk("r2_ready", mem_req_ready, 1);
    tick();
    mem_req_valid = 1'b0;
    chk("r2_addr", dram_req_addr, 28'h158);
    chk("r2_tag", dram_req_tag, 8'h02);
    tick();
    chk("r2_done", dram_req_valid, 0);

    // Two lines of read data, first held unconsumed for 10 cycles
    for (int i = 0; i < 4; i++) begin
      pl[i] = rep4(32'h1000_0000 + 32'(i));
      ql[i] = rep4(32'h2000_0000 + 32'(i));
    end
    mem_rsp_ready  = 1'b0;
    dram_rsp_valid = 1'b1;
    dram_rsp_tag   = 8'h01;
    for (int i = 0; i < 4; i++) begin
      dram_rsp_data = pl[i];
      tick();
    end
    dram_rsp_tag  = 8'h02;
    dram_rsp_data = ql[0];
    chk("l1_valid", mem_rsp_valid, 1);
    chk("l1_tag", mem_rsp_tag, 8'h01);
    chk("l1_data", mem_rsp_data, pl);
    for (int c = 0; c < 10; c++) begin
      chk("l1_hold_stall", dram_rsp_ready, 0);
      chk("l1_hold_valid", mem_rsp_valid, 1);
      tick();
    end
    chk("l1_hold_data", mem_rsp_data, pl);
    mem_rsp_ready = 1'b1;
    tick();
    mem_rsp_ready = 1'b0;
    chk("l1_taken", mem_rsp_valid, 0);
    chk("l2_ready", dram_rsp_ready, 1);
    for (int i = 0; i < 4; i++) begin
      dram_rsp_data = ql[i];
      tick();
    end
    dram_rsp_valid = 1'b0;
    chk("l2_valid", mem_rsp_valid, 1);
    chk("l2_tag", mem_rsp_tag, 8'h02);
    chk("l2_data", mem_rsp_data, ql);
    mem_rsp_ready = 1'b1;
    tick();
    chk("l2_taken", mem_rsp_valid, 0);

    // Reset in the middle of a write burst and a read line
    dram_req_ready = 1'b0;
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b1;
    mem_req_addr   = 26'h3;
    mem_req_byteen = '1;
    mem_req_data   = wl;
    tick();
    mem_req_valid  = 1'b0;
    dram_rsp_valid = 1'b1;
    dram_rsp_tag   = 8'h33;
    dram_rsp_data  = rep4(32'hDEAD_0000);
    tick();
    dram_rsp_data  = rep4(32'hDEAD_0001);
    tick();
    dram_rsp_valid = 1'b0;
    chk("mr_stalled", dram_req_valid, 1);
    reset = 1'b0;
    #1;
    chk("mr_dram_valid", dram_req_valid, 0);
    chk("mr_req_ready", mem_req_ready, 1);
    chk("mr_rsp_valid", mem_rsp_valid, 0);
    chk("mr_rsp_ready", dram_rsp_ready, 1);
    chk("mr_addr", dram_req_addr, 0);
    chk("mr_data", dram_req_data, 0);
    chk("mr_tag", dram_req_tag, 0);
    chk("mr_line", mem_rsp_data, 0);
    tick();
    reset          = 1'b1;
    dram_req_ready = 1'b1;
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b0;
    mem_req_addr   = 26'h1;
    mem_req_tag    = 8'h44;
    tick();
    mem_req_valid = 1'b0;
    chk("pr_addr", dram_req_addr, 28'h4);
    chk("pr_tag", dram_req_tag, 8'h44);
    dram_rsp_valid = 1'b1;
    dram_rsp_tag   = 8'h44;
    for (int i = 0; i < 4; i++) begin
      ql[i] = rep4(32'h4400_0000 + 32'(i));
      dram_rsp_data = ql[i];
      tick();
    end
    dram_rsp_valid = 1'b0;
    chk("pr_valid", mem_rsp_valid, 1);
    chk("pr_tag_rsp", mem_rsp_tag, 8'h44);
    chk("pr_data", mem_rsp_data, ql);
    tick();
    chk("pr_taken", mem_rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
